// File: rtl/pulse_pacer_if.sv
// Event-side bundle of the pulse pacer: event/clear requests in, paced pulse and status out.
// The pacer uses the slave view; whatever produces events uses the master view.
interface pulse_pacer_if #(
    parameter int CNT_W = 4
);
    logic             ev_in;
    logic             ovf_clr;
    logic             pulse_out;
    logic [CNT_W-1:0] pending;
    logic             busy;
    logic             ovf;

    modport master (
        output ev_in, ovf_clr,
        input  pulse_out, pending, busy, ovf
    );

    modport slave (
        input  ev_in, ovf_clr,
        output pulse_out, pending, busy, ovf
    );
endinterface

// File: rtl/pulse_pacer.sv
// Queues single-cycle events as a saturating count and re-emits them as pulses
// separated by GAP idle cycles, ahead of a 1-bit pulse handshake synchronizer.
module pulse_pacer #(
    parameter int GAP   = 8,
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    pulse_pacer_if.slave bus
);
    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_GAP   = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [7:0]       GAP_LOAD = 8'(GAP - 1);

    logic [0:0]       state;
    logic [7:0]       gap_cnt;
    logic [CNT_W-1:0] pending_q;
    logic             pulse_q;
    logic             ovf_q;

    logic             issue;
    logic             drop;
    logic             accept;
    logic [CNT_W-1:0] pending_nxt;

    // An issue frees a slot in the same edge, so a full queue only drops when nothing leaves.
    always_comb begin
        issue       = (state == ST_IDLE) && ((pending_q != '0) || bus.ev_in);
        drop        = bus.ev_in && (pending_q == CNT_MAX) && !issue;
        accept      = bus.ev_in && !drop;
        pending_nxt = pending_q + CNT_W'(accept) - CNT_W'(issue);
    end

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gap_cnt   <= '0;
            pending_q <= '0;
            pulse_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_nxt;

            if (drop) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    pulse_q <= issue;
                    if (issue) begin
                        state   <= ST_GAP;
                        gap_cnt <= GAP_LOAD;
                    end
                end
                default: begin
                    pulse_q <= 1'b0;
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.pending   = pending_q;
    assign bus.ovf       = ovf_q;
    // Derived from registers only, so ev_in never reaches busy combinationally.
    assign bus.busy      = (state != ST_IDLE) || (pending_q != '0);
endmodule

// File: tb/tb_pulse_pacer.sv
// Self-checking bench for pulse_pacer: GAP=8 and GAP=1 instances driven in lockstep
// and compared each cycle against an event-level model (pulse timing + queue count).
module tb_pulse_pacer;
    localparam int CNT_W    = 4;
    localparam int PEND_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        int pend;
        bit ovf;
        int since;  // cycles since the last emitted pulse, saturating at the gap
        bit pulse;
    } model_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    model_t m8;
    model_t m1;

    pulse_pacer_if #(.CNT_W(CNT_W)) if8 ();
    pulse_pacer_if #(.CNT_W(CNT_W)) if1 ();

    pulse_pacer #(.GAP(8), .CNT_W(CNT_W)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    pulse_pacer #(.GAP(1), .CNT_W(CNT_W)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A pulse may leave once at least `gap` cycles have passed since the previous one;
    // the queue counts events not yet emitted and refuses arrivals beyond PEND_MAX.
    function automatic model_t model_step(model_t m, int gap, bit ev, bit clr, bit r);
        model_t n;
        bit     can_issue;
        bit     dropped;
        n = m;
        if (r) begin
            n.pend  = 0;
            n.ovf   = 1'b0;
            n.pulse = 1'b0;
            n.since = gap;
            return n;
        end
        dropped   = 1'b0;
        can_issue = (m.since >= gap) && (m.pend > 0 || ev);
        if (can_issue) begin
            n.pulse = 1'b1;
            n.since = 0;
            n.pend  = m.pend + (ev ? 1 : 0) - 1;
        end else begin
            n.pulse = 1'b0;
            n.since = (m.since >= gap) ? gap : m.since + 1;
            if (ev) begin
                if (m.pend == PEND_MAX) dropped = 1'b1;
                else n.pend = m.pend + 1;
            end
        end
        if (dropped) n.ovf = 1'b1;
        else if (clr) n.ovf = 1'b0;
        return n;
    endfunction

    function automatic logic [6:0] exp_vec(model_t m, int gap);
        logic busy;
        busy = (m.since < gap) || (m.pend != 0);
        return {m.pulse, 4'(m.pend), busy, m.ovf};
    endfunction

    task automatic step(input bit ev, input bit clr, input bit r);
        if8.ev_in   = ev;
        if1.ev_in   = ev;
        if8.ovf_clr = clr;
        if1.ovf_clr = clr;
        rst         = r;
        @(posedge clk);
        m8 = model_step(m8, 8, ev, clr, r);
        m1 = model_step(m1, 1, ev, clr, r);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if ({if8.pulse_out, if8.pending, if8.busy, if8.ovf} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_g8: got %b want %b", {if8.pulse_out, if8.pending, if8.busy, if8.ovf}, 7'b0);
        end
        n_cmp++;
        if ({if1.pulse_out, if1.pending, if1.busy, if1.ovf} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_g1: got %b want %b", {if1.pulse_out, if1.pending, if1.busy, if1.ovf}, 7'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({if8.pulse_out, if8.pending, if8.busy, if8.ovf} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want %b", {if8.pulse_out, if8.pending, if8.busy, if8.ovf}, 7'b0);
        end
    endtask

    task automatic test_single();
        int pulses;
        int busy_cycles;
        step(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (if8.pulse_out !== 1'b1 || if8.pending !== 4'd0) begin
            n_fail++;
            $display("FAIL single_latency: got pulse=%b pending=%0d want pulse=1 pending=0", if8.pulse_out, if8.pending);
        end
        pulses      = int'(if8.pulse_out);
        busy_cycles = int'(if8.busy);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            pulses      += int'(if8.pulse_out);
            busy_cycles += int'(if8.busy);
            n_cmp++;
            if ({if8.pulse_out, if8.pending, if8.busy, if8.ovf} !== exp_vec(m8, 8)) begin
                n_fail++;
                $display("FAIL single_g8 @%0d: got %b want %b", i, {if8.pulse_out, if8.pending, if8.busy, if8.ovf}, exp_vec(m8, 8));
            end
        end
        n_cmp++;
        if (pulses !== 1 || busy_cycles !== 8) begin
            n_fail++;
            $display("FAIL single_counts: got pulses=%0d busy=%0d want pulses=1 busy=8", pulses, busy_cycles);
        end
    endtask

    task automatic test_back_to_back();
        int pos[$];
        int peak;
        int want[5] = '{0, 9, 18, 27, 36};
        peak = 0;
        for (int i = 0; i < 55; i++) begin
            step(i < 5, 1'b0, 1'b0);
            if (if8.pulse_out === 1'b1) pos.push_back(i);
            if (int'(if8.pending) > peak) peak = int'(if8.pending);
            n_cmp++;
            if ({if8.pulse_out, if8.pending, if8.busy, if8.ovf} !== exp_vec(m8, 8)) begin
                n_fail++;
                $display("FAIL b2b_g8 @%0d: got %b want %b", i, {if8.pulse_out, if8.pending, if8.busy, if8.ovf}, exp_vec(m8, 8));
            end
        end
        n_cmp++;
        if (pos.size() != 5 || peak != 4 || if8.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_summary: got pulses=%0d peak=%0d ovf=%b want 5/4/0", pos.size(), peak, if8.ovf);
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (pos[k] != want[k]) begin
                    n_fail++;
                    $display("FAIL b2b_spacing[%0d]: got %0d want %0d", k, pos[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int pulses;
        step(1'b0, 1'b0, 1'b1);
        pulses = 0;
        // Two issues fall inside the burst, so the 18th back-to-back event is the first dropped.
        for (int i = 0; i < 18; i++) begin
            step(1'b1, 1'b0, 1'b0);
            pulses += int'(if8.pulse_out);
        end
        n_cmp++;
        if (if8.pending !== 4'd15 || if8.ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got pending=%0d ovf=%b want 15/1", if8.pending, if8.ovf);
        end
        step(1'b0, 1'b1, 1'b0);
        pulses += int'(if8.pulse_out);
        n_cmp++;
        if (if8.ovf !== 1'b0 || {if8.pulse_out, if8.pending, if8.busy, if8.ovf} !== exp_vec(m8, 8)) begin
            n_fail++;
            $display("FAIL ovf_clr: got %b want %b", {if8.pulse_out, if8.pending, if8.busy, if8.ovf}, exp_vec(m8, 8));
        end
        for (int i = 0; i < 150; i++) begin
            step(1'b0, 1'b0, 1'b0);
            pulses += int'(if8.pulse_out);
        end
        n_cmp++;
        if (pulses != 17 || if8.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_drain: got pulses=%0d busy=%b want 17/0", pulses, if8.busy);
        end
    endtask

    task automatic test_full_cancel();
        int  cancels;
        bit  ev;
        bit  at_full;
        step(1'b0, 1'b0, 1'b1);
        cancels = 0;
        for (int i = 0; i < 200 && cancels < 2; i++) begin
            ev      = (m8.pend < PEND_MAX) || (m8.since >= 8);
            at_full = ev && (m8.pend == PEND_MAX) && (m8.since >= 8);
            step(ev, 1'b0, 1'b0);
            n_cmp++;
            if ({if8.pulse_out, if8.pending, if8.busy, if8.ovf} !== exp_vec(m8, 8)) begin
                n_fail++;
                $display("FAIL fill_g8 @%0d: got %b want %b", i, {if8.pulse_out, if8.pending, if8.busy, if8.ovf}, exp_vec(m8, 8));
            end
            if (at_full) begin
                cancels++;
                n_cmp++;
                if (if8.pending !== 4'd15 || if8.ovf !== 1'b0 || if8.pulse_out !== 1'b1) begin
                    n_fail++;
                    $display("FAIL full_cancel: got pending=%0d ovf=%b pulse=%b want 15/0/1", if8.pending, if8.ovf, if8.pulse_out);
                end
            end
        end
        n_cmp++;
        if (cancels != 2) begin
            n_fail++;
            $display("FAIL full_cancel_reached: got %0d want 2", cancels);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (if8.pending !== 4'd3) begin
            n_fail++;
            $display("FAIL rstmid_backlog: got %0d want 3", if8.pending);
        end
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            n_cmp++;
            if ({if8.pulse_out, if8.pending, if8.busy, if8.ovf} !== 7'b0) begin
                n_fail++;
                $display("FAIL rstmid @%0d: got %b want %b", i, {if8.pulse_out, if8.pending, if8.busy, if8.ovf}, 7'b0);
            end
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_gap1();
        logic [7:0] seq;
        step(1'b0, 1'b0, 1'b1);
        seq = '0;
        for (int i = 0; i < 8; i++) begin
            step(i < 4, 1'b0, 1'b0);
            seq = {seq[6:0], if1.pulse_out};
            n_cmp++;
            if ({if1.pulse_out, if1.pending, if1.busy, if1.ovf} !== exp_vec(m1, 1)) begin
                n_fail++;
                $display("FAIL gap1_g1 @%0d: got %b want %b", i, {if1.pulse_out, if1.pending, if1.busy, if1.ovf}, exp_vec(m1, 1));
            end
        end
        n_cmp++;
        if (seq !== 8'b1010_1010) begin
            n_fail++;
            $display("FAIL gap1_seq: got %b want %b", seq, 8'b1010_1010);
        end
    endtask

    task automatic test_random();
        int  rate;
        bit  prev8;
        bit  prev1;
        prev8 = 1'b0;
        prev1 = 1'b0;
        rate  = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) rate = int'($urandom_range(100));
            step($urandom_range(99) < rate, $urandom_range(31) == 0, $urandom_range(499) == 0);
            n_cmp++;
            if ({if8.pulse_out, if8.pending, if8.busy, if8.ovf} !== exp_vec(m8, 8)) begin
                n_fail++;
                $display("FAIL rand_g8 @%0d: got %b want %b", i, {if8.pulse_out, if8.pending, if8.busy, if8.ovf}, exp_vec(m8, 8));
            end
            n_cmp++;
            if ({if1.pulse_out, if1.pending, if1.busy, if1.ovf} !== exp_vec(m1, 1)) begin
                n_fail++;
                $display("FAIL rand_g1 @%0d: got %b want %b", i, {if1.pulse_out, if1.pending, if1.busy, if1.ovf}, exp_vec(m1, 1));
            end
            n_cmp++;
            if ((prev8 && if8.pulse_out === 1'b1) || (prev1 && if1.pulse_out === 1'b1)) begin
                n_fail++;
                $display("FAIL rand_double_pulse @%0d: got g8=%b g1=%b after a pulse want 0", i, if8.pulse_out, if1.pulse_out);
            end
            prev8 = (if8.pulse_out === 1'b1);
            prev1 = (if1.pulse_out === 1'b1);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        if8.ev_in   = 1'b0;
        if1.ev_in   = 1'b0;
        if8.ovf_clr = 1'b0;
        if1.ovf_clr = 1'b0;
        m8          = '0;
        m1          = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_cancel();
        test_reset_mid();
        test_gap1();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
